// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/response encodings, response-FSM
// state type and the registered data-phase owner.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRSP_OKAY  = 1'b0;
  localparam logic HRSP_ERROR = 1'b1;

  // Owner index is stored zero-extended to a fixed width so the struct can
  // live in a non-parameterised package; SEL_BITS must not exceed this.
  localparam int OWNER_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DP   = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } resp_state_e;

  typedef struct packed {
    logic                   valid;
    logic                   dflt;
    logic [OWNER_IDX_W-1:0] idx;
  } owner_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Two-cycle AHB ERROR responder. Used for unmapped regions (start) and for
// the watchdog (force_err: the current cycle already carried ERR1 values,
// so only the ERR2 cycle remains).
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        force_err,
  output resp_state_e state,
  output logic        ready,
  output logic        resp
);

  // Advance ERR1 -> ERR2 -> (new ERR1 or IDLE)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        ERR1:    state <= ERR2;
        default: begin
          if (force_err)  state <= ERR2;
          else if (start) state <= ERR1;
          else            state <= IDLE;
        end
      endcase
    end
  end

  // ERR1 stalls the master, ERR2 completes; both signal ERROR
  always_comb begin
    ready = (state != ERR1);
    resp  = ((state == ERR1) || (state == ERR2)) ? HRSP_ERROR : HRSP_OKAY;
  end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master, multi-slave AHB-Lite interconnect: address decode, data-phase
// owner register, response mux, default ERROR slave and wait-state watchdog.
module ahb_lite_interconnect
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_BITS       = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             HREADY,
  output logic                             HRSP,
  output logic [NUM_SLAVES-1:0]            HSEL_S,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]            HRSP_S,
  output logic                             timeout_pulse
);

  localparam int WCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCNT_W-1:0] WLIMIT = WCNT_W'(TIMEOUT_CYCLES);

  logic [SEL_BITS-1:0]   region;
  logic                  trans_active;
  logic                  region_dflt;
  logic                  accept;
  owner_t                owner;
  resp_state_e           dflt_state;
  resp_state_e           cur_state;
  logic                  dflt_ready;
  logic                  dflt_resp;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic                  s_ready;
  logic                  s_rsp;
  logic [WCNT_W-1:0]     wcnt;
  logic                  fire;
  logic                  addr_unused;

  assign region       = HADDR[ADDR_WIDTH-1 -: SEL_BITS];
  assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign region_dflt  = (OWNER_IDX_W'(region) >= OWNER_IDX_W'(NUM_SLAVES));
  assign accept       = HREADY;
  // Offset bits within a region are consumed by the slaves, not here.
  assign addr_unused  = ^HADDR[ADDR_WIDTH-SEL_BITS-1:0];

  // Combinational address decode into per-slave selects
  always_comb begin
    HSEL_S = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL_S[i] = trans_active && (region == SEL_BITS'(i));
    end
  end

  // Capture the data-phase owner whenever an address phase is accepted
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      owner <= '0;
    end else if (accept) begin
      owner.valid <= trans_active;
      owner.dflt  <= region_dflt;
      owner.idx   <= OWNER_IDX_W'(region);
    end
  end

  ahb_default_slave u_default_slave (
    .clk       (HCLK),
    .rst_n     (HRESET),
    .start     (accept && trans_active && region_dflt),
    .force_err (fire),
    .state     (dflt_state),
    .ready     (dflt_ready),
    .resp      (dflt_resp)
  );

  // Select the owning slave's response signals
  always_comb begin
    s_rdata = '0;
    s_ready = 1'b1;
    s_rsp   = HRSP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (owner.idx == OWNER_IDX_W'(i)) begin
        s_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        s_ready = HREADYOUT_S[i];
        s_rsp   = HRSP_S[i];
      end
    end
  end

  // Overall response state: the ERROR sequence overrides any slave phase
  always_comb begin
    if (dflt_state != IDLE)                  cur_state = dflt_state;
    else if (owner.valid && !owner.dflt)     cur_state = DP;
    else                                     cur_state = IDLE;
  end

  // Watchdog trips only when the threshold is reached and the slave is still stalling
  always_comb begin
    fire = (TIMEOUT_CYCLES > 0) && (cur_state == DP) && !s_ready && (wcnt == WLIMIT);
  end

  // Count consecutive wait states of the current slave data phase
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      wcnt <= '0;
    end else if (accept) begin
      wcnt <= '0;
    end else if ((cur_state == DP) && !s_ready && (wcnt != WLIMIT)) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  // Drive the master-side response from the current state
  always_comb begin
    HRDATA        = '0;
    HREADY        = 1'b1;
    HRSP          = HRSP_OKAY;
    timeout_pulse = fire;
    case (cur_state)
      DP: begin
        if (fire) begin
          HREADY = 1'b0;
          HRSP   = HRSP_ERROR;
        end else begin
          HRDATA = s_rdata;
          HREADY = s_ready;
          HRSP   = s_rsp;
        end
      end
      ERR1, ERR2: begin
        HREADY = dflt_ready;
        HRSP   = dflt_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect with default parameters.
module tb_ahb_lite_interconnect;

  logic         HCLK;
  logic         HRESET;
  logic [19:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic         HRSP;
  logic [3:0]   HSEL_S;
  logic [127:0] HRDATA_S;
  logic [3:0]   HREADYOUT_S;
  logic [3:0]   HRSP_S;
  logic         timeout_pulse;

  int vecs;
  int errs;

  ahb_lite_interconnect dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .HADDR         (HADDR),
    .HTRANS        (HTRANS),
    .HRDATA        (HRDATA),
    .HREADY        (HREADY),
    .HRSP          (HRSP),
    .HSEL_S        (HSEL_S),
    .HRDATA_S      (HRDATA_S),
    .HREADYOUT_S   (HREADYOUT_S),
    .HRSP_S        (HRSP_S),
    .timeout_pulse (timeout_pulse)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge HCLK);
    #1;
  endtask

  task automatic at_neg;
    @(negedge HCLK);
  endtask

  // Idle/reset-like response values
  task automatic chk_idle(input string tag);
    chk({tag, "_hready"}, 32'(HREADY), 32'd1);
    chk({tag, "_hrsp"},   32'(HRSP),   32'd0);
    chk({tag, "_hrdata"}, HRDATA,      32'd0);
    chk({tag, "_hsel"},   32'(HSEL_S), 32'd0);
    chk({tag, "_tmo"},    32'(timeout_pulse), 32'd0);
  endtask

  initial begin
    vecs        = 0;
    errs        = 0;
    HRESET      = 1'b0;
    HADDR       = '0;
    HTRANS      = 2'b00;
    HRDATA_S    = '0;
    HREADYOUT_S = 4'b1111;
    HRSP_S      = 4'b0000;

    // Reset held
    #3;
    chk_idle("reset");
    next_cycle();
    HRESET = 1'b1;
    at_neg();
    chk_idle("post_reset");

    // Zero-wait read from slave1
    next_cycle();
    HADDR  = 20'h20004;
    HTRANS = 2'b10;
    at_neg();
    chk("s1_hsel", 32'(HSEL_S), 32'h2);
    chk("s1_addr_hready", 32'(HREADY), 32'd1);
    next_cycle();
    HTRANS = 2'b00;
    HRDATA_S[1*32 +: 32] = 32'hDEADBEEF;
    at_neg();
    chk("s1_hrdata", HRDATA, 32'hDEADBEEF);
    chk("s1_hready", 32'(HREADY), 32'd1);
    chk("s1_hrsp",   32'(HRSP), 32'd0);
    next_cycle();
    at_neg();
    chk_idle("s1_after");

    // Back-to-back unmapped NONSEQs (regions 4 and 5)
    next_cycle();
    HADDR  = 20'h80000;
    HTRANS = 2'b10;
    at_neg();
    chk("um_hsel", 32'(HSEL_S), 32'd0);
    next_cycle();
    HADDR = 20'hA0000;
    at_neg();
    chk("um_e1_hready", 32'(HREADY), 32'd0);
    chk("um_e1_hrsp",   32'(HRSP), 32'd1);
    chk("um_e1_hsel",   32'(HSEL_S), 32'd0);
    next_cycle();
    at_neg();
    chk("um_e2_hready", 32'(HREADY), 32'd1);
    chk("um_e2_hrsp",   32'(HRSP), 32'd1);
    next_cycle();
    HTRANS = 2'b00;
    at_neg();
    chk("um_e3_hready", 32'(HREADY), 32'd0);
    chk("um_e3_hrsp",   32'(HRSP), 32'd1);
    next_cycle();
    at_neg();
    chk("um_e4_hready", 32'(HREADY), 32'd1);
    chk("um_e4_hrsp",   32'(HRSP), 32'd1);
    next_cycle();
    at_neg();
    chk_idle("um_after");

    // Slave2 with five wait states
    next_cycle();
    HADDR  = 20'h40000;
    HTRANS = 2'b10;
    at_neg();
    chk("s2_hsel", 32'(HSEL_S), 32'h4);
    next_cycle();
    HTRANS = 2'b00;
    HREADYOUT_S[2] = 1'b0;
    HRDATA_S[2*32 +: 32] = 32'h12345678;
    for (int w = 0; w < 5; w++) begin
      at_neg();
      chk("s2_wait_hready", 32'(HREADY), 32'd0);
      chk("s2_wait_hrsp",   32'(HRSP), 32'd0);
      chk("s2_wait_tmo",    32'(timeout_pulse), 32'd0);
      next_cycle();
    end
    HREADYOUT_S[2] = 1'b1;
    at_neg();
    chk("s2_done_hready", 32'(HREADY), 32'd1);
    chk("s2_done_hrsp",   32'(HRSP), 32'd0);
    chk("s2_done_hrdata", HRDATA, 32'h12345678);
    chk("s2_done_tmo",    32'(timeout_pulse), 32'd0);

    // Slave0 ERROR passes through unchanged
    next_cycle();
    HADDR  = 20'h00010;
    HTRANS = 2'b10;
    at_neg();
    chk("s0e_hsel", 32'(HSEL_S), 32'h1);
    next_cycle();
    HTRANS = 2'b00;
    HREADYOUT_S[0] = 1'b0;
    HRSP_S[0] = 1'b1;
    at_neg();
    chk("s0e_1_hready", 32'(HREADY), 32'd0);
    chk("s0e_1_hrsp",   32'(HRSP), 32'd1);
    next_cycle();
    HREADYOUT_S[0] = 1'b1;
    at_neg();
    chk("s0e_2_hready", 32'(HREADY), 32'd1);
    chk("s0e_2_hrsp",   32'(HRSP), 32'd1);
    next_cycle();
    HRSP_S[0] = 1'b0;

    // Slave3 hangs: watchdog fires on data-phase cycle 17
    HADDR  = 20'h60000;
    HTRANS = 2'b10;
    at_neg();
    chk("s3_hsel", 32'(HSEL_S), 32'h8);
    next_cycle();
    HTRANS = 2'b00;
    HREADYOUT_S[3] = 1'b0;
    for (int w = 0; w < 16; w++) begin
      at_neg();
      chk("s3_wait_hready", 32'(HREADY), 32'd0);
      chk("s3_wait_hrsp",   32'(HRSP), 32'd0);
      chk("s3_wait_tmo",    32'(timeout_pulse), 32'd0);
      next_cycle();
    end
    at_neg();
    chk("s3_c17_hready", 32'(HREADY), 32'd0);
    chk("s3_c17_hrsp",   32'(HRSP), 32'd1);
    chk("s3_c17_tmo",    32'(timeout_pulse), 32'd1);
    next_cycle();
    HADDR  = 20'h00000;
    HTRANS = 2'b10;
    at_neg();
    chk("s3_c18_hready", 32'(HREADY), 32'd1);
    chk("s3_c18_hrsp",   32'(HRSP), 32'd1);
    chk("s3_c18_tmo",    32'(timeout_pulse), 32'd0);
    chk("s0_hsel",       32'(HSEL_S), 32'h1);
    next_cycle();
    HTRANS = 2'b00;
    HREADYOUT_S[3] = 1'b1;
    HRDATA_S[0*32 +: 32] = 32'hCAFEF00D;
    at_neg();
    chk("s0_hrdata", HRDATA, 32'hCAFEF00D);
    chk("s0_hready", 32'(HREADY), 32'd1);
    chk("s0_hrsp",   32'(HRSP), 32'd0);

    // Asynchronous reset during a slave1 wait state
    next_cycle();
    HADDR  = 20'h20000;
    HTRANS = 2'b10;
    next_cycle();
    HTRANS = 2'b00;
    HREADYOUT_S[1] = 1'b0;
    HRDATA_S[1*32 +: 32] = 32'h0BADF00D;
    at_neg();
    chk("ar_wait_hready", 32'(HREADY), 32'd0);
    #2;
    HRESET = 1'b0;
    #1;
    chk_idle("ar_async");
    next_cycle();
    HRESET = 1'b1;
    HREADYOUT_S[1] = 1'b1;
    HRDATA_S[1*32 +: 32] = 32'h55AA33CC;
    HADDR  = 20'h20008;
    HTRANS = 2'b10;
    at_neg();
    chk("ar_hsel", 32'(HSEL_S), 32'h2);
    next_cycle();
    HTRANS = 2'b00;
    at_neg();
    chk("ar_hrdata", HRDATA, 32'h55AA33CC);
    chk("ar_hready", 32'(HREADY), 32'd1);
    chk("ar_hrsp",   32'(HRSP), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
